// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encodings and the default operand width.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
interface iter_muldiv_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic                   start_i;
    logic [1:0]             op_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   annul_i;
    logic                   stallreq_o;
    logic                   busy_o;
    logic                   ready_o;
    logic [2*WIDTH-1:0]     result_o;
    logic                   div_by_zero_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  stallreq_o, busy_o, ready_o, result_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output stallreq_o, busy_o, ready_o, result_o, div_by_zero_o
    );

endinterface

// File: rtl/iter_muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step,
// operating on a {hi, lo} accumulator with an unsigned WIDTH-bit operand.
module iter_muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    always_comb begin
        addend = acc_i[0] ? b_i : '0;
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Partial remainder is hi shifted left with the next dividend bit;
        // diff[WIDTH] set means the trial subtraction underflowed.
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, b_i};

        if (div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative signed/unsigned multiply/divide unit with start/ready handshake,
// pipeline stall request and flush annul; fixed latency of WIDTH+2 cycles.
module iter_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          resetn,
    iter_muldiv_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic                 div_q, div_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 dbz_q, dbz_d;

    logic                 accept;
    logic                 in_div;
    logic                 in_dbz;
    logic                 s1, s2;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     acc_hi, acc_lo;
    logic [2*WIDTH-1:0]   fix_res;

    iter_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_i (div_q),
        .acc_i (acc_q),
        .b_i   (b_q),
        .acc_o (acc_step)
    );

    // Operand decode: signed ops work on magnitudes, signs are re-applied in FIX.
    always_comb begin
        accept = (state_q == S_IDLE) && bus.start_i && !bus.annul_i;
        in_div = op_is_div(bus.op_i);
        in_dbz = in_div && (bus.opdata2_i == '0);
        s1     = op_is_signed(bus.op_i) && bus.opdata1_i[WIDTH-1];
        s2     = op_is_signed(bus.op_i) && bus.opdata2_i[WIDTH-1];
        mag1   = s1 ? -bus.opdata1_i : bus.opdata1_i;
        mag2   = s2 ? -bus.opdata2_i : bus.opdata2_i;
    end

    always_comb begin
        acc_hi = acc_q[2*WIDTH-1:WIDTH];
        acc_lo = acc_q[WIDTH-1:0];
        if (div_q) begin
            fix_res = {(neg_rem_q ? -acc_hi : acc_hi),
                       (neg_res_q ? -acc_lo : acc_lo)};
        end else begin
            fix_res = neg_res_q ? -acc_q : acc_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_d       = b_q;
        acc_d     = acc_q;
        res_d     = res_q;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dbz_d = in_dbz;
                    if (in_dbz) begin
                        res_d   = {bus.opdata1_i, {WIDTH{1'b1}}};
                        state_d = S_DONE;
                    end else begin
                        div_d     = in_div;
                        neg_res_d = s1 ^ s2;
                        neg_rem_d = s1;
                        b_d       = in_div ? mag2 : mag1;
                        acc_d     = in_div ? {{WIDTH{1'b0}}, mag1}
                                           : {{WIDTH{1'b0}}, mag2};
                        cnt_d     = CW'(WIDTH);
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = fix_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            div_q     <= 1'b0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        bus.ready_o       = (state_q == S_DONE) && !bus.annul_i;
        bus.busy_o        = (state_q != S_IDLE);
        bus.stallreq_o    = accept || (state_q == S_RUN) || (state_q == S_FIX);
        bus.result_o      = res_q;
        bus.div_by_zero_o = bus.ready_o && dbz_q;
    end

endmodule

// File: tb/tb_iter_muldiv.sv
// Scoreboard bench for iter_muldiv: directed vectors push expected results,
// a monitor pops and compares on every ready_o pulse (value, flag and cycle).
module tb_iter_muldiv;
    import muldiv_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic resetn;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    exp_t q32[$];
    exp_t q8[$];
    logic [63:0] last_res;

    iter_muldiv_if #(.WIDTH(32)) bus32 ();
    iter_muldiv_if #(.WIDTH(8))  bus8 ();

    iter_muldiv #(.WIDTH(32)) u_dut32 (.clk(clk), .resetn(resetn), .bus(bus32));
    iter_muldiv #(.WIDTH(8))  u_dut8  (.clk(clk), .resetn(resetn), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: one pass per negedge, counting cycles and scoring ready pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus32.ready_o === 1'b1) begin
                if (q32.size() == 0) begin
                    check("unexpected_ready32", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    check("result32", bus32.result_o, e.res);
                    check("dbz32", {63'd0, bus32.div_by_zero_o}, {63'd0, e.dbz});
                    check("ready_cycle32", 64'(cyc), 64'(e.cyc));
                end
            end
            if (bus8.ready_o === 1'b1) begin
                if (q8.size() == 0) begin
                    check("unexpected_ready8", 64'd1, 64'd0);
                end else begin
                    e = q8.pop_front();
                    check("result8", {48'd0, bus8.result_o}, e.res);
                    check("dbz8", {63'd0, bus8.div_by_zero_o}, {63'd0, e.dbz});
                    check("ready_cycle8", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Drives start_i for exactly one cycle (cycle 0) and queues the expectation.
    task automatic issue(input bit w8, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] res, input logic dbz,
                         input int unsigned lat, input bit push);
        exp_t e;
        @(posedge clk); #1;
        if (w8) begin
            bus8.op_i      = op;
            bus8.opdata1_i = a[7:0];
            bus8.opdata2_i = b[7:0];
            bus8.start_i   = 1'b1;
        end else begin
            bus32.op_i      = op;
            bus32.opdata1_i = a;
            bus32.opdata2_i = b;
            bus32.start_i   = 1'b1;
        end
        e.res = res;
        e.dbz = dbz;
        e.cyc = cyc + 1 + lat;
        if (push) begin
            if (w8) q8.push_back(e);
            else    q32.push_back(e);
            last_res = res;
        end
        @(negedge clk);
        check("stall_cycle0", {63'd0, (w8 ? bus8.stallreq_o : bus32.stallreq_o)}, 64'd1);
        @(posedge clk); #1;
        bus8.start_i  = 1'b0;
        bus32.start_i = 1'b0;
        bus32.opdata1_i = 32'hDEAD_BEEF;
        bus32.opdata2_i = 32'h0BAD_F00D;
    endtask

    task automatic wait_done(input bit w8);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((w8 ? bus8.busy_o : bus32.busy_o) && n < 100);
        check("busy_timeout", {63'd0, (w8 ? bus8.busy_o : bus32.busy_o)}, 64'd0);
    endtask

    initial begin
        resetn = 1'b0;
        bus32.start_i = 1'b0; bus32.op_i = 2'b00; bus32.opdata1_i = '0;
        bus32.opdata2_i = '0; bus32.annul_i = 1'b0;
        bus8.start_i = 1'b0;  bus8.op_i = 2'b00;  bus8.opdata1_i = '0;
        bus8.opdata2_i = '0;  bus8.annul_i = 1'b0;
        last_res = '0;
        #3;
        check("rst_ready", {63'd0, bus32.ready_o}, 64'd0);
        check("rst_busy", {63'd0, bus32.busy_o}, 64'd0);
        check("rst_stall", {63'd0, bus32.stallreq_o}, 64'd0);
        check("rst_result", bus32.result_o, 64'd0);
        check("rst_dbz", {63'd0, bus32.div_by_zero_o}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // MULU all-ones, with the stall profile over the whole operation
        issue(1'b0, OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 34, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            check($sformatf("stall_cycle%0d", k), {63'd0, bus32.stallreq_o},
                  (k < 34) ? 64'd1 : 64'd0);
        end
        wait_done(1'b0);

        issue(1'b0, OP_MUL,  32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 34, 1'b1);
        wait_done(1'b0);
        issue(1'b0, OP_DIV,  32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34, 1'b1);
        wait_done(1'b0);
        issue(1'b0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 34, 1'b1);
        wait_done(1'b0);
        issue(1'b0, OP_DIVU, 32'd100,       32'd7,        64'h0000_0002_0000_000E, 1'b0, 34, 1'b1);
        wait_done(1'b0);
        issue(1'b0, OP_DIVU, 32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF, 1'b1, 1, 1'b1);
        wait_done(1'b0);
        issue(1'b0, OP_MUL,  32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0, 34, 1'b1);
        wait_done(1'b0);
        issue(1'b0, OP_DIV,  32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 34, 1'b1);
        wait_done(1'b0);
        issue(1'b0, OP_DIV,  32'hFFFF_FFFF, 32'd0,        64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 1'b1);
        wait_done(1'b0);

        // Annul a DIV in cycle 10; a MULU accepted in cycle 12 must be unaffected
        begin
            logic [63:0] kept;
            kept = last_res;
            issue(1'b0, OP_DIV, 32'hFFFF_FF9C, 32'd3, 64'd0, 1'b0, 34, 1'b0);
            repeat (9) @(posedge clk);
            #1 bus32.annul_i = 1'b1;
            @(posedge clk); #1 bus32.annul_i = 1'b0;
            @(negedge clk);
            check("annul_busy", {63'd0, bus32.busy_o}, 64'd0);
            check("annul_result_kept", bus32.result_o, kept);
            issue(1'b0, OP_MULU, 32'd12345, 32'h0001_0000, 64'h0000_0000_3039_0000, 1'b0, 34, 1'b1);
            wait_done(1'b0);
        end

        // Asynchronous reset in the middle of cycle 5 of a MUL
        issue(1'b0, OP_MUL, 32'd9, 32'd9, 64'd0, 1'b0, 34, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_ready", {63'd0, bus32.ready_o}, 64'd0);
        check("midrst_busy", {63'd0, bus32.busy_o}, 64'd0);
        check("midrst_stall", {63'd0, bus32.stallreq_o}, 64'd0);
        check("midrst_result", bus32.result_o, 64'd0);
        check("midrst_dbz", {63'd0, bus32.div_by_zero_o}, 64'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // Narrow instance: latency WIDTH+2 = 10
        issue(1'b1, OP_MULU, 32'hFF, 32'hFF, 64'h0000_0000_0000_FE01, 1'b0, 10, 1'b1);
        wait_done(1'b1);
        issue(1'b1, OP_DIV, 32'hF9, 32'h02, 64'h0000_0000_0000_FFFD, 1'b0, 10, 1'b1);
        wait_done(1'b1);

        repeat (3) @(negedge clk);
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
